// File: rtl/pulsegen_pkg.sv
// Shared opcodes, framing bytes and FSM encodings for the pulse generator
// command path; the checksum byte is enabled by CMD_REPLY_CHECKSUM_EN.
package pulsegen_pkg;

    localparam logic [7:0] STATE0    = 8'h00;
    localparam logic [7:0] PER       = 8'h01;
    localparam logic [7:0] ED        = 8'h02;
    localparam logic [7:0] OUTER_PER = 8'h03;
    localparam logic [7:0] PRINT     = 8'h04;
    localparam logic [7:0] CLEAR     = 8'h05;

    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] NL      = 8'h0A;
    localparam logic [7:0] ERR_HDR = 8'hEE;

    function automatic int ed_bits(input int cb, input int chl);
        return 2 * cb + chl + 1;
    endfunction

    function automatic int nbytes(input int bits);
        return (bits + 7) / 8;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_ISSUE,
        ST_BUSY
    } tx_state_t;

    typedef enum logic [2:0] {
        PH_HDR,
        PH_IDX,
        PH_PAY,
        PH_CHK,
        PH_CR,
        PH_NL
    } tx_phase_t;

    typedef enum logic [1:0] {
        SND_SEND,
        SND_WAIT_START,
        SND_WAIT_DONE
    } snd_state_t;

endpackage

// File: rtl/cmd_reply_tx_uart_byte_sender.sv
// Single-byte UART handshake: strobe transmit, wait for busy to rise
// (bounded by START_TMO) and to fall again.
module uart_byte_sender
    import pulsegen_pkg::*;
#(
    parameter int START_TMO = 15
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       byte_done,
    output logic       timeout,
    input  logic       is_transmitting,
    output logic       transmit,
    output logic [7:0] tx_byte
);

    localparam int CW = $clog2(START_TMO + 1);

    snd_state_t    r_state;
    logic [CW-1:0] r_cnt;

    assign byte_ready = (r_state == SND_SEND) && !is_transmitting;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state   <= SND_SEND;
            r_cnt     <= '0;
            transmit  <= 1'b0;
            tx_byte   <= 8'h00;
            byte_done <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            transmit  <= 1'b0;
            byte_done <= 1'b0;
            timeout   <= 1'b0;
            unique case (r_state)
                SND_SEND: begin
                    if (byte_valid && byte_ready) begin
                        transmit <= 1'b1;
                        tx_byte  <= byte_data;
                        r_cnt    <= '0;
                        r_state  <= SND_WAIT_START;
                    end
                end
                SND_WAIT_START: begin
                    if (is_transmitting) begin
                        r_state <= SND_WAIT_DONE;
                    end else if (r_cnt == CW'(START_TMO)) begin
                        timeout <= 1'b1;
                        r_state <= SND_SEND;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    if (!is_transmitting) begin
                        byte_done <= 1'b1;
                        r_state   <= SND_SEND;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/cmd_reply_tx.sv
// Readback reply transmitter: op, idx, payload LSB first, [chk], CR, NL.
// Checksum byte present when CMD_REPLY_CHECKSUM_EN is defined.
module cmd_reply_tx
    import pulsegen_pkg::*;
#(
    parameter int COUNT_BITS = 32,
    parameter int CH_LOG2    = 3,
    parameter int ED_MAX     = 64,
    parameter int START_TMO  = 15
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          req_valid,
    input  logic [7:0]                    req_op,
    input  logic [7:0]                    req_idx,
    output logic                          req_ready,
    input  logic [(1<<CH_LOG2)-1:0]       rd_state0,
    input  logic [COUNT_BITS-1:0]         rd_period,
    input  logic [COUNT_BITS-1:0]         rd_outer_period,
    output logic [7:0]                    rd_ed_idx,
    input  logic [2*COUNT_BITS+CH_LOG2:0] rd_ed_data,
    input  logic                          is_transmitting,
    output logic                          transmit,
    output logic [7:0]                    tx_byte,
    output logic                          done,
    output logic                          tx_err
);

    localparam int CH_MAX = 1 << CH_LOG2;
    localparam int EDW    = ed_bits(COUNT_BITS, CH_LOG2);
    localparam int NB_S0  = nbytes(CH_MAX);
    localparam int NB_PER = nbytes(COUNT_BITS);
    localparam int NB_ED  = nbytes(EDW);
    localparam int BUF_W  = 8 * max3(NB_S0, NB_PER, NB_ED);

    tx_state_t        r_state;
    tx_phase_t        r_ph;
    logic [7:0]       r_op;
    logic [7:0]       r_idx;
    logic             r_err;
    logic [BUF_W-1:0] r_buf;
    logic [7:0]       r_cnt;

    logic [BUF_W-1:0] w_val;
    logic [7:0]       w_nb;
    logic [7:0]       w_byte;
    logic [7:0]       w_chk;
    logic             w_req_err;
    logic             w_bvalid;
    logic             w_bready;
    logic             w_acc;
    logic             w_bdone;
    logic             w_tmo;
    tx_phase_t        w_after;
    tx_phase_t        w_ph_next;

    assign req_ready = (r_state == ST_IDLE);
    assign tx_err    = w_tmo;
    assign w_bvalid  = (r_state == ST_CAPTURE) || (r_state == ST_ISSUE);
    assign w_acc     = w_bvalid && w_bready;

    assign w_req_err = !((req_op == STATE0) || (req_op == PER) ||
                         (req_op == ED) || (req_op == OUTER_PER)) ||
                       ((req_op == ED) && (int'(req_idx) >= ED_MAX));

`ifdef CMD_REPLY_CHECKSUM_EN
    logic [7:0] r_chk;
    assign w_after = PH_CHK;
    assign w_chk   = r_chk;

    // running XOR over header, index and payload bytes as they are issued
    always_ff @(posedge sys_clk) begin
        if (rst || r_state == ST_IDLE) begin
            r_chk <= 8'h00;
        end else if (w_acc && (r_ph == PH_HDR || r_ph == PH_IDX ||
                               r_ph == PH_PAY)) begin
            r_chk <= r_chk ^ w_byte;
        end
    end
`else
    assign w_after = PH_CR;
    assign w_chk   = 8'h00;
`endif

    always_comb begin
        w_val = '0;
        w_nb  = 8'd0;
        unique case (1'b1)
            (r_op == STATE0): begin
                w_val[CH_MAX-1:0] = rd_state0;
                w_nb = 8'(NB_S0);
            end
            (r_op == PER): begin
                w_val[COUNT_BITS-1:0] = rd_period;
                w_nb = 8'(NB_PER);
            end
            (r_op == ED): begin
                w_val[EDW-1:0] = rd_ed_data;
                w_nb = 8'(NB_ED);
            end
            (r_op == OUTER_PER): begin
                w_val[COUNT_BITS-1:0] = rd_outer_period;
                w_nb = 8'(NB_PER);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = NL;
        unique case (r_ph)
            PH_HDR:  w_byte = r_err ? ERR_HDR : r_op;
            PH_IDX:  w_byte = r_err ? r_op : r_idx;
            PH_PAY:  w_byte = r_buf[7:0];
            PH_CHK:  w_byte = w_chk;
            PH_CR:   w_byte = CR;
            default: w_byte = NL;
        endcase
    end

    always_comb begin
        w_ph_next = PH_NL;
        unique case (r_ph)
            PH_HDR:  w_ph_next = PH_IDX;
            PH_IDX:  w_ph_next = (r_cnt == 8'd0) ? w_after : PH_PAY;
            PH_PAY:  w_ph_next = (r_cnt == 8'd1) ? w_after : PH_PAY;
            PH_CHK:  w_ph_next = PH_CR;
            default: w_ph_next = PH_NL;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ph      <= PH_HDR;
            r_op      <= 8'h00;
            r_idx     <= 8'h00;
            r_err     <= 1'b0;
            r_buf     <= '0;
            r_cnt     <= 8'd0;
            rd_ed_idx <= 8'h00;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op      <= req_op;
                        r_idx     <= req_idx;
                        rd_ed_idx <= req_idx;
                        r_err     <= w_req_err;
                        r_ph      <= PH_HDR;
                        r_state   <= ST_FETCH;
                    end
                end
                ST_FETCH: r_state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    r_buf   <= w_val;
                    r_cnt   <= r_err ? 8'd0 : w_nb;
                    r_state <= w_acc ? ST_BUSY : ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (w_acc) r_state <= ST_BUSY;
                end
                default: begin
                    if (w_tmo) begin
                        r_state <= ST_IDLE;
                    end else if (w_bdone) begin
                        if (r_ph == PH_NL) begin
                            done    <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ph    <= w_ph_next;
                            r_state <= ST_ISSUE;
                            if (r_ph == PH_PAY) begin
                                r_buf <= r_buf >> 8;
                                r_cnt <= r_cnt - 8'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    uart_byte_sender #(
        .START_TMO(START_TMO)
    ) u_sender (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .byte_valid     (w_bvalid),
        .byte_data      (w_byte),
        .byte_ready     (w_bready),
        .byte_done      (w_bdone),
        .timeout        (w_tmo),
        .is_transmitting(is_transmitting),
        .transmit       (transmit),
        .tx_byte        (tx_byte)
    );

endmodule

// File: tb/tb_cmd_reply_tx.sv
// Scoreboard bench for cmd_reply_tx with a 10-cycle UART busy model.
// Honours CMD_REPLY_CHECKSUM_EN when building expected frames.
module tb_cmd_reply_tx;

    localparam logic [8:0] TOK_DONE = 9'h100;
    localparam logic [8:0] TOK_ERR  = 9'h101;
    localparam logic [67:0] ED3_VAL = 68'h1_2345_6789_ABCD_EF01;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [7:0]  req_op;
    logic [7:0]  req_idx;
    logic        req_ready;
    logic [7:0]  rd_state0;
    logic [31:0] rd_period;
    logic [31:0] rd_outer_period;
    logic [7:0]  rd_ed_idx;
    logic [67:0] rd_ed_data = '0;
    logic        is_transmitting = 1'b0;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        done;
    logic        tx_err;

    logic [8:0]  exp_q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          uart_mute = 1'b0;
    int          ucnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cmd_reply_tx dut (
        .sys_clk        (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_idx        (req_idx),
        .req_ready      (req_ready),
        .rd_state0      (rd_state0),
        .rd_period      (rd_period),
        .rd_outer_period(rd_outer_period),
        .rd_ed_idx      (rd_ed_idx),
        .rd_ed_data     (rd_ed_data),
        .is_transmitting(is_transmitting),
        .transmit       (transmit),
        .tx_byte        (tx_byte),
        .done           (done),
        .tx_err         (tx_err)
    );

    // UART: busy from the cycle after the strobe, for 10 cycles
    always @(posedge clk) begin
        if (ucnt > 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) is_transmitting <= 1'b0;
        end else if (transmit && !uart_mute) begin
            is_transmitting <= 1'b1;
            ucnt <= 10;
        end
    end

    // edge store with a registered read port
    always @(posedge clk)
        rd_ed_data <= (rd_ed_idx == 8'd3) ? ED3_VAL : 68'hF_5555_5555_5555_5555;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic check_tok(input logic [8:0] got);
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %0h, expected none", got);
        end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL sequence: got %0h, expected %0h", got, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (transmit) check_tok({1'b0, tx_byte});
        if (done)     check_tok(TOK_DONE);
        if (tx_err)   check_tok(TOK_ERR);
    end

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [71:0] pay, input int n);
        logic [7:0] c;
        logic [7:0] b;
        c = b0 ^ b1;
        exp_q.push_back({1'b0, b0});
        exp_q.push_back({1'b0, b1});
        for (int i = 0; i < n; i++) begin
            b = pay[8*i +: 8];
            c = c ^ b;
            exp_q.push_back({1'b0, b});
        end
`ifdef CMD_REPLY_CHECKSUM_EN
        exp_q.push_back({1'b0, c});
`endif
        exp_q.push_back(9'h00D);
        exp_q.push_back(9'h00A);
        exp_q.push_back(TOK_DONE);
    endtask

    task automatic do_req(input logic [7:0] op, input logic [7:0] idx,
                          output int t_acc);
        bit ok;
        ok = 1'b0;
        t_acc = -1;
        @(negedge clk);
        req_op = op;
        req_idx = idx;
        req_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                t_acc = cyc;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        #1 req_valid = 1'b0;
        check("req_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_tx(input logic [7:0] val, input bit any,
                           output int t);
        t = -1;
        for (int i = 0; i < 400 && t < 0; i++) begin
            @(negedge clk);
            if (transmit && (any || tx_byte == val)) t = cyc;
        end
        check("wait_transmit_seen", 32'(t >= 0), 32'd1);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (15) @(negedge clk);
        check(nm, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, tx0, te;
        bit bad;
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 8'h00;
        req_idx = 8'h00;
        rd_state0 = 8'hA5;
        rd_period = 32'h1234_5678;
        rd_outer_period = 32'h0D0A_0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_transmit", 32'(transmit), 32'd0);
        check("reset_tx_byte", 32'(tx_byte), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_tx_err", 32'(tx_err), 32'd0);
        check("reset_rd_ed_idx", 32'(rd_ed_idx), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);

        push_frame(8'h01, 8'h00, 72'h1234_5678, 4);
        do_req(8'h01, 8'h00, t);
        drain("per_frame_drained");

        push_frame(8'h02, 8'h03, {4'h0, ED3_VAL}, 9);
        do_req(8'h02, 8'h03, t);
        @(negedge clk);
        check("ed_rd_idx_at_T1", 32'(rd_ed_idx), 32'd3);
        wait_tx(8'h00, 1'b1, tx0);
        check("ed_first_strobe_T3", 32'(tx0 - t), 32'd3);
        drain("ed_frame_drained");

        push_frame(8'hEE, 8'h07, 72'h0, 0);
        do_req(8'h07, 8'h00, t);
        drain("unknown_op_drained");

        push_frame(8'hEE, 8'h02, 72'h0, 0);
        do_req(8'h02, 8'd64, t);
        drain("ed_oob_drained");

        push_frame(8'h02, 8'd63, 72'hF_5555_5555_5555_5555, 9);
        do_req(8'h02, 8'd63, t);
        drain("ed_last_idx_drained");

        push_frame(8'h00, 8'h05, 72'hA5, 1);
        do_req(8'h00, 8'h05, t);
        drain("state0_drained");

        push_frame(8'h03, 8'h09, 72'h0D0A_0000, 4);
        do_req(8'h03, 8'h09, t);
        drain("outer_raw_crlf_drained");

        uart_mute = 1'b1;
        exp_q.push_back(9'h001);
        exp_q.push_back(TOK_ERR);
        do_req(8'h01, 8'h00, t);
        wait_tx(8'h00, 1'b1, tx0);
        te = -1;
        for (int i = 0; i < 60 && te < 0; i++) begin
            @(negedge clk);
            if (tx_err) te = cyc;
        end
        check("tmo_err_delay", 32'(te - tx0), 32'd16);
        @(negedge clk);
        check("tmo_ready_after", 32'(req_ready), 32'd1);
        repeat (30) @(negedge clk);
        check("tmo_no_more_events", 32'(exp_q.size()), 32'd0);
        uart_mute = 1'b0;

        push_frame(8'h01, 8'h00, 72'h1234_5678, 4);
        do_req(8'h01, 8'h00, t);
        wait_tx(8'h34, 1'b0, tx0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_transmit", 32'(transmit), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        repeat (20) @(negedge clk);
        check("rst_no_more_events", 32'(exp_q.size()), 32'd0);
        push_frame(8'h01, 8'h00, 72'h1234_5678, 4);
        do_req(8'h01, 8'h00, t);
        drain("post_rst_frame_drained");

        push_frame(8'h01, 8'h11, 72'h1234_5678, 4);
        do_req(8'h01, 8'h11, t);
        @(negedge clk);
        req_op = 8'h00;
        req_valid = 1'b1;
        bad = 1'b0;
        te = -1;
        for (int i = 0; i < 400 && te < 0; i++) begin
            if (i == 20) rd_period = 32'hDEAD_BEEF;
            if (done) begin
                te = cyc;
                req_valid = 1'b0;
            end else if (req_ready) begin
                bad = 1'b1;
            end
            if (te < 0) @(negedge clk);
        end
        req_valid = 1'b0;
        check("busy_ready_low", 32'(bad), 32'd0);
        check("busy_done_seen", 32'(te >= 0), 32'd1);
        drain("busy_frame_drained");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
